// File: rtl/if_stage_fifo_reg.sv
// ---------------------------------------------------------------------------
// if_stage_fifo_reg
//   This block sits between the IF and ID stages. It is a small circular buffer
//   that holds up to DEPTH fetched {pc, instruction} pairs, so fetch can keep
//   running while decode is stalled. Both sides use valid/ready handshakes.
//   freeze holds all state. flush empties the buffer at the next edge.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset; clears all state
//   freeze         hazard stall: blocks push and pop, holds contents
//   flush          branch-taken flush: discards every entry at the next edge
//   in_valid       IF presents a fetched pair
//   in_ready       buffer accepts a pair this cycle
//   pc_in          fetched pc
//   instruction_in fetched instruction
//   out_valid      head entry is available to ID
//   out_ready      ID consumes the head this cycle
//   pc             head pc (0 when empty)
//   instruction    head instruction (0 when empty)
//   count          number of stored entries
// ---------------------------------------------------------------------------
module if_stage_fifo_reg #(
  parameter int BIT_NUMBER = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_NUMBER-1:0] pc_in,
  input  logic [BIT_NUMBER-1:0] instruction_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_NUMBER-1:0] pc,
  output logic [BIT_NUMBER-1:0] instruction,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 2 * BIT_NUMBER;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("if_stage_fifo_reg: DEPTH must be a power of two and at least 2");
  end

  logic [ENT_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);

  // Ready depends only on local state and the pipeline controls. It never
  // looks at out_ready, so no combinational ready path passes through here.
  // As a result a full buffer refuses a push even in a cycle where it pops.
  assign in_ready  = !full  && !freeze && !flush;
  assign out_valid = !empty && !freeze && !flush;

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  // The head stays visible during freeze. It is forced to 0 when the buffer
  // is empty, so stale data left behind by a flush never shows up.
  assign head        = storage[rd_ptr];
  assign pc          = empty ? '0 : head[ENT_W-1:BIT_NUMBER];
  assign instruction = empty ? '0 : head[BIT_NUMBER-1:0];
  assign count       = cnt;

  // Because DEPTH is a power of two, the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= {pc_in, instruction_in};
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_fifo_reg.sv
module tb_if_stage_fifo_reg;

  localparam int BN    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             freeze;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [BN-1:0]    pc_in;
  logic [BN-1:0]    instruction_in;
  logic             out_valid;
  logic             out_ready;
  logic [BN-1:0]    pc;
  logic [BN-1:0]    instruction;
  logic [CNT_W-1:0] count;

  if_stage_fifo_reg #(.BIT_NUMBER(BN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .instruction(instruction), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the buffer seen as a FIFO queue of {pc, instruction}.
  logic [2*BN-1:0] q[$];
  logic            last_push;
  logic            last_pop;
  logic [BN-1:0]   last_pop_pc;

  typedef struct {
    logic          fr, fl, iv, ordy;
    logic [BN-1:0] p, ins;
    logic          e_ir, e_ov;
    logic [BN-1:0] e_pc, e_ins;
    int            e_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic fr, fl, iv, ordy,
                              input logic [BN-1:0] p, ins,
                              input logic e_ir, e_ov,
                              input logic [BN-1:0] e_pc, e_ins,
                              input int e_cnt);
    vec_t v;
    v.fr = fr; v.fl = fl; v.iv = iv; v.ordy = ordy; v.p = p; v.ins = ins;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_ins = e_ins; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [BN-1:0] act, input logic [BN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fr, fl, iv, ordy, input logic [BN-1:0] p, ins);
    freeze = fr; flush = fl; in_valid = iv; out_ready = ordy;
    pc_in = p; instruction_in = ins;
  endtask

  // Compare every output against the queue model for the current inputs.
  task automatic model_check(input string tag);
    logic          e_ir, e_ov;
    logic [BN-1:0] e_pc, e_ins;
    e_ir  = (q.size() != DEPTH) && !freeze && !flush;
    e_ov  = (q.size() != 0) && !freeze && !flush;
    e_pc  = (q.size() != 0) ? q[0][2*BN-1:BN] : '0;
    e_ins = (q.size() != 0) ? q[0][BN-1:0] : '0;
    chk({tag, "_in_ready"},    BN'(in_ready),  BN'(e_ir));
    chk({tag, "_out_valid"},   BN'(out_valid), BN'(e_ov));
    chk({tag, "_pc"},          pc,             e_pc);
    chk({tag, "_instruction"}, instruction,    e_ins);
    chk({tag, "_count"},       BN'(count),     BN'(q.size()));
  endtask

  // Decide the handshakes from the model before the edge, then advance.
  // Called shortly after a falling edge; returns on the next falling edge.
  task automatic edge_update();
    logic can_push, can_pop;
    can_push = in_valid && (q.size() != DEPTH) && !freeze && !flush;
    can_pop  = out_ready && (q.size() != 0) && !freeze && !flush;
    last_push = can_push;
    last_pop  = can_pop;
    last_pop_pc = (q.size() != 0) ? q[0][2*BN-1:BN] : '0;
    @(posedge clk);
    if (flush) begin
      q.delete();
      last_push = 1'b0;
      last_pop  = 1'b0;
    end else begin
      if (can_pop)  void'(q.pop_front());
      if (can_push) q.push_back({pc_in, instruction_in});
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic fr, fl, iv, ordy, input logic [BN-1:0] p, ins,
                       input string tag);
    drive(fr, fl, iv, ordy, p, ins);
    #1;
    model_check(tag);
    edge_update();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, '0, '0);
    #2;
    chk("rst_count", BN'(count), '0);
    chk("rst_out_valid", BN'(out_valid), '0);
    chk("rst_in_ready", BN'(in_ready), BN'(1));
    chk("rst_pc", pc, '0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();

    // Single pass, then fill to full with refused 5th push, then drain in order.
    vecs[0]  = mk(0,0,1,1, 32'h4,  32'hE3A00001, 1,0, 32'h0, 32'h0, 0);
    vecs[1]  = mk(0,0,0,1, 32'h0,  32'h0,        1,1, 32'h4, 32'hE3A00001, 1);
    vecs[2]  = mk(0,0,0,0, 32'h0,  32'h0,        1,0, 32'h0, 32'h0, 0);
    vecs[3]  = mk(0,0,1,0, 32'h0,  32'h10000000, 1,0, 32'h0, 32'h0, 0);
    vecs[4]  = mk(0,0,1,0, 32'h4,  32'h10000004, 1,1, 32'h0, 32'h10000000, 1);
    vecs[5]  = mk(0,0,1,0, 32'h8,  32'h10000008, 1,1, 32'h0, 32'h10000000, 2);
    vecs[6]  = mk(0,0,1,0, 32'hC,  32'h1000000C, 1,1, 32'h0, 32'h10000000, 3);
    vecs[7]  = mk(0,0,1,1, 32'h10, 32'h10000010, 0,1, 32'h0, 32'h10000000, 4);
    vecs[8]  = mk(0,0,0,1, 32'h0,  32'h0,        1,1, 32'h4, 32'h10000004, 3);
    vecs[9]  = mk(0,0,0,1, 32'h0,  32'h0,        1,1, 32'h8, 32'h10000008, 2);
    vecs[10] = mk(0,0,0,1, 32'h0,  32'h0,        1,1, 32'hC, 32'h1000000C, 1);
    vecs[11] = mk(0,0,0,0, 32'h0,  32'h0,        1,0, 32'h0, 32'h0, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fr, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].p, vecs[i].ins);
      #1;
      chk($sformatf("vec%0d_in_ready", i),  BN'(in_ready),  BN'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), BN'(out_valid), BN'(vecs[i].e_ov));
      chk($sformatf("vec%0d_pc", i),        pc,             vecs[i].e_pc);
      chk($sformatf("vec%0d_instr", i),     instruction,    vecs[i].e_ins);
      chk($sformatf("vec%0d_count", i),     BN'(count),     BN'(vecs[i].e_cnt));
      edge_update();
    end

    // Wrap-around: 10 pairs, out_ready toggling, order preserved.
    begin
      int nxt = 0;
      int rcv = 0;
      int cyc = 0;
      while (rcv < 10 && cyc < 80) begin
        cycle(0, 0, (nxt < 10), cyc[0], BN'(nxt * 4), BN'(32'hC0DE0000 + nxt), "wrap");
        if (last_push) nxt++;
        if (last_pop) begin
          chk("wrap_order", last_pop_pc, BN'(rcv * 4));
          rcv++;
        end
        chk("wrap_cnt_le4", BN'(count <= CNT_W'(DEPTH)), BN'(1));
        cyc++;
      end
      chk("wrap_all_received", BN'(rcv), BN'(10));
    end

    // Freeze with two entries held.
    cycle(0, 0, 1, 0, 32'h8, 32'hAAAA0008, "frz_fill");
    cycle(0, 0, 1, 0, 32'hC, 32'hAAAA000C, "frz_fill");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 32'h99, 32'h99);
      #1;
      chk("frz_in_ready", BN'(in_ready), '0);
      chk("frz_out_valid", BN'(out_valid), '0);
      chk("frz_pc", pc, 32'h8);
      chk("frz_count", BN'(count), BN'(2));
      edge_update();
    end
    cycle(0, 0, 0, 1, '0, '0, "frz_release");
    chk("frz_popped_head", last_pop_pc, 32'h8);
    cycle(0, 0, 0, 1, '0, '0, "frz_drain");

    // Flush and freeze together with three entries.
    cycle(0, 0, 1, 0, 32'h20, 32'h20, "fl_fill");
    cycle(0, 0, 1, 0, 32'h24, 32'h24, "fl_fill");
    cycle(0, 0, 1, 0, 32'h28, 32'h28, "fl_fill");
    cycle(1, 1, 1, 1, 32'h30, 32'h30, "fl_both");
    drive(0, 0, 0, 0, '0, '0);
    #1;
    chk("fl_count", BN'(count), '0);
    chk("fl_out_valid", BN'(out_valid), '0);
    chk("fl_pc", pc, '0);
    edge_update();
    cycle(0, 0, 1, 0, 32'h40, 32'h4040, "fl_push");
    drive(0, 0, 0, 1, '0, '0);
    #1;
    chk("fl_new_head_valid", BN'(out_valid), BN'(1));
    chk("fl_new_head_pc", pc, 32'h40);
    edge_update();

    // Asynchronous reset in the middle of a cycle with three entries.
    cycle(0, 0, 1, 0, 32'h50, 32'h50, "ar_fill");
    cycle(0, 0, 1, 0, 32'h54, 32'h54, "ar_fill");
    cycle(0, 0, 1, 0, 32'h58, 32'h58, "ar_fill");
    drive(0, 0, 0, 0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", BN'(count), '0);
    chk("ar_out_valid", BN'(out_valid), '0);
    chk("ar_pc", pc, '0);
    chk("ar_instruction", instruction, '0);
    chk("ar_in_ready", BN'(in_ready), BN'(1));
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    cycle(0, 0, 1, 0, 32'h60, 32'h60, "ar_push");
    chk("ar_push_accepted", BN'(count), BN'(1));

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
            1'($urandom), 1'($urandom), $urandom, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_fifo_reg.md
Name: if_stage_fifo_reg

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched {pc, instruction} pairs in a small circular buffer with valid/ready handshakes on both sides.
- Fetch can run ahead of a stalled decode stage.
- Keeps the existing freeze and flush controls; sits between the IF stage and the ID stage.

Parameters:
- BIT_NUMBER, 32, width of pc and instruction fields.
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-high; clears all state.
- freeze  input  1  hazard stall: blocks both push and pop, holds contents.
- flush  input  1  branch-taken flush: discards all entries at the next edge.
- in_valid  input  1  IF stage presents a fetched pair.
- in_ready  output  1  buffer accepts a pair this cycle.
- pc_in  input  BIT_NUMBER  fetched pc.
- instruction_in  input  BIT_NUMBER  fetched instruction.
- out_valid  output  1  head entry available to ID.
- out_ready  input  1  ID consumes the head this cycle.
- pc  output  BIT_NUMBER  head pc.
- instruction  output  BIT_NUMBER  head instruction.
- count  output  CNT_W  current number of stored entries.

Behaviour:
- Storage: DEPTH x 2*BIT_NUMBER register array.
- Pointers: wr_ptr and rd_ptr, $clog2(DEPTH) bits each. Pointers wrap naturally from DEPTH-1 to 0.
- Occupancy: an explicit counter cnt, 0..DEPTH, drives count.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, cnt=0, storage cleared to 0. Outputs: in_ready=1 (if freeze=0), out_valid=0, pc=0, instruction=0, count=0.
- in_ready = (cnt != DEPTH) & !freeze & !flush. Combinational, with no dependence on out_ready, so there is no ready path through the block.
- out_valid = (cnt != 0) & !freeze & !flush.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Push: at the edge, write {pc_in, instruction_in} to storage[wr_ptr], then wr_ptr+1.
- Pop: at the edge, rd_ptr+1.
- cnt update: +1 on push only, -1 on pop only, unchanged on both or neither.
- pc/instruction = storage[rd_ptr] when cnt != 0, else 0. They remain visible during freeze (out_valid low, value stable).
- Latency: a pair pushed at edge N is presented with out_valid=1 in the cycle after edge N, provided cnt was 0 and freeze=0. Minimum latency is 1 cycle.
- Throughput: 1 pair/cycle sustained when 0 < cnt < DEPTH with push and pop every cycle.
- Full (cnt=DEPTH): in_ready=0, even if out_ready=1 in the same cycle. A pop frees a slot for the next cycle.
- Empty (cnt=0): out_valid=0; out_ready is ignored.
- flush=1 (synchronous, highest priority after rst): at the edge, wr_ptr=rd_ptr=0 and cnt=0. Storage contents are don't-care but pc/instruction read 0. Neither push nor pop occurs in that cycle, because in_ready and out_valid are forced 0.
- flush and freeze together: flush wins and the buffer empties.
- freeze=1 without flush: no push, no pop, all state held.
- rst asserted mid-operation: immediate clear regardless of clock. After rst deasserts, the first push is accepted at the next edge.
- No overflow or underflow is possible through the ports. Illegal DEPTH (not a power of two, or <2) is rejected with an elaboration-time $error.

Test Plan:
- Reset/idle: rst pulse mid-cycle with cnt=3 -> immediately count=0, out_valid=0, pc=0, instruction=0; in_ready=1 once freeze=0.
- Single pass: push pc=0x4, instr=0xE3A00001 at edge 1, out_ready=1 -> out_valid=1 in cycle after edge 1 with those values; popped at edge 2; count returns 0.
- Fill/full: out_ready=0, push pc=0x0,0x4,0x8,0xC (DEPTH=4) -> count=4, in_ready=0. A 5th in_valid with pc=0x10 is not accepted. Then pop 4 -> outputs 0x0,0x4,0x8,0xC in order.
- Wrap-around: push/pop continuously for 10 pairs pc=0x0..0x24 with out_ready toggling every other cycle -> output order preserved across pointer wrap; count never exceeds 4; no entry lost or duplicated.
- Freeze: cnt=2 (heads 0x8,0xC), freeze=1 for 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, pc stays 0x8, count stays 2. After release, 0x8 pops on the first edge.
- Flush vs freeze: cnt=3, flush=1 and freeze=1 and in_valid=1 in the same cycle -> after edge count=0, out_valid=0, pc=0; the presented pair is not stored. The next push of pc=0x40 appears as the head one cycle later.
